// File: rtl/matrix_stream_loader.sv
// Byte-stream front end for a parallel N x N matrix multiplier: loads A then B
// element by element, pulses start, captures C on done and streams it back out.
module matrix_stream_loader #(
    parameter int DATA_W  = 8,
    parameter int N       = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*N*DATA_W-1:0]   A_flat,
    output logic [N*N*DATA_W-1:0]   B_flat,
    output logic                    start,
    input  logic                    done,
    input  logic [N*N*DATA_W-1:0]   C_flat,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err
);

    localparam int NN    = N * N;
    localparam int CNT_W = $clog2(2 * NN);
    localparam int IDX_W = $clog2(NN);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [IDX_W-1:0]       r_j;
    logic [TMR_W-1:0]       r_timer;
    logic [DATA_W-1:0]      r_a [NN];
    logic [DATA_W-1:0]      r_b [NN];
    logic [DATA_W-1:0]      r_c [NN];
    logic                   r_in_ready;
    logic                   r_start;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_err;

    logic [DATA_W-1:0]      w_c [NN];
    logic [IDX_W-1:0]       w_load_idx;
    logic                   w_in_fire;
    logic                   w_load_a;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_load_a   = r_count < CNT_W'(NN);
    assign w_load_idx = w_load_a ? r_count[IDX_W-1:0] : IDX_W'(r_count - CNT_W'(NN));

    // Element k sits at bits [(NN-1-k)*DATA_W +: DATA_W]: row-major, (0,0) in the MSBs.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a full default first so no latch is inferred.
        A_flat = '0;
        B_flat = '0;
        w_c    = '{default: '0};
        for (int k = 0; k < NN; k++) begin
            A_flat[(NN-1-k)*DATA_W +: DATA_W] = r_a[k];
            B_flat[(NN-1-k)*DATA_W +: DATA_W] = r_b[k];
            w_c[k] = C_flat[(NN-1-k)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_j         <= '0;
            r_timer     <= '0;
            r_in_ready  <= 1'b0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            // NOTE: the element stores are small register files, so they are cleared with the rest of the state.
            for (int k = 0; k < NN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        if (w_load_a) begin
                            r_a[w_load_idx] <= in_data;
                        end else begin
                            r_b[w_load_idx] <= in_data;
                        end
                        if (r_count == CNT_W'(2 * NN - 1)) begin
                            r_count    <= '0;
                            r_in_ready <= 1'b0;
                            r_start    <= 1'b1;
                            r_err      <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end

                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (done) begin
                        r_c         <= w_c;
                        r_out_data  <= w_c[0];
                        r_out_valid <= 1'b1;
                        r_j         <= '0;
                        r_state     <= S_DRAIN;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        // Abort: the C buffer keeps the previous result.
                        r_err      <= 1'b1;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_j == IDX_W'(NN - 1)) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_j        <= r_j + IDX_W'(1);
                            r_out_data <= r_c[r_j + IDX_W'(1)];
                        end
                    end
                end

                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign start     = r_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;
    assign busy      = !((r_state == S_LOAD) && (r_count == '0));

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: table of full runs with hand-computed results,
// plus timeout, mid-load reset and stray-done sequences, against a 3x3 multiplier model.
module tb_matrix_stream_loader;

    localparam int DW = 8;
    localparam int FW = 72;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] A_flat;
    logic [FW-1:0] B_flat;
    logic          start;
    logic          done;
    logic [FW-1:0] C_flat;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          err;

    logic          model_done  = 1'b0;
    logic [FW-1:0] model_c     = '0;
    logic          glitch_done = 1'b0;
    logic          mult_en;
    int            start_cnt   = 0;
    int            total       = 0;
    int            bad         = 0;

    assign done   = model_done | glitch_done;
    assign C_flat = glitch_done ? {FW{1'b1}} : model_c;

    matrix_stream_loader #(.DATA_W(DW), .N(3), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_flat    (A_flat),
        .B_flat    (B_flat),
        .start     (start),
        .done      (done),
        .C_flat    (C_flat),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] a;
        logic [FW-1:0] b;
        logic [FW-1:0] c;
        logic          gap;
        int            stall_j;
        int            stall_len;
        int            load_glitch;
        logic          drain_glitch;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [FW-1:0] mat_mul(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW-1:0] c;
        logic [DW-1:0] s;
        c = '0;
        for (int r = 0; r < 3; r++) begin
            for (int cc = 0; cc < 3; cc++) begin
                s = '0;
                for (int m = 0; m < 3; m++) begin
                    s = s + a[(8-(r*3+m))*8 +: 8] * b[(8-(m*3+cc))*8 +: 8];
                end
                c[(8-(r*3+cc))*8 +: 8] = s;
            end
        end
        return c;
    endfunction

    // Multiplier model: result 3 cycles after start, done held one extra cycle with a corrupted C.
    initial begin
        forever begin
            @(negedge clk);
            if (start && mult_en) begin
                repeat (3) @(negedge clk);
                model_c    = mat_mul(A_flat, B_flat);
                model_done = 1'b1;
                @(negedge clk);
                model_c = ~model_c;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    always @(negedge clk) if (start) start_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic send_elem(input logic [DW-1:0] e);
        int n;
        n = 0;
        in_data  = e;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("in_ready_wait", in_ready, 1'b1);
        @(negedge clk);
    endtask

    // Loads A then B; returns at the negedge just after the 18th accept.
    task automatic load_and_start(input vec_t v);
        logic [DW-1:0] e;
        for (int k = 0; k < 18; k++) begin
            if (k == v.load_glitch) begin
                in_valid    = 1'b0;
                glitch_done = 1'b1;
                @(negedge clk);
                glitch_done = 1'b0;
                check1("load_glitch_busy", busy, 1'b1);
                check1("load_glitch_in_ready", in_ready, 1'b1);
                check1("load_glitch_out_valid", out_valid, 1'b0);
            end
            e = (k < 9) ? v.a[(8-k)*8 +: 8] : v.b[(17-k)*8 +: 8];
            send_elem(e);
            if (v.gap && k < 17) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check1("start_high", start, 1'b1);
        check1("start_in_ready_low", in_ready, 1'b0);
        check1("start_busy", busy, 1'b1);
        check("A_flat", A_flat, v.a);
        check("B_flat", B_flat, v.b);
    endtask

    task automatic drain(input vec_t v);
        int n;
        logic [DW-1:0] exp_e;
        for (int j = 0; j < 9; j++) begin
            exp_e = v.c[(8-j)*8 +: 8];
            n = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check1("out_valid", out_valid, 1'b1);
            check("out_data", FW'(out_data), FW'(exp_e));
            if (j == v.stall_j) begin
                out_ready = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    if (v.drain_glitch && s == 0) glitch_done = 1'b1;
                    @(negedge clk);
                    glitch_done = 1'b0;
                    check1("stall_valid_hold", out_valid, 1'b1);
                    check("stall_data_hold", FW'(out_data), FW'(exp_e));
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check1("drain_end_valid", out_valid, 1'b0);
        check1("drain_end_busy", busy, 1'b0);
        check1("drain_end_in_ready", in_ready, 1'b1);
        check("A_flat_stable", A_flat, v.a);
        check("B_flat_stable", B_flat, v.b);
    endtask

    task automatic run_vec(input vec_t v);
        load_and_start(v);
        @(negedge clk);
        check1("start_one_cycle", start, 1'b0);
        check1("err_cleared", err, 1'b0);
        drain(v);
    endtask

    initial begin
        tbl[0] = '{a: 72'h090807060504030201, b: 72'h010203040506070809, c: 72'h5A728A36455412181E,
                   gap: 1'b0, stall_j: -1, stall_len: 0, load_glitch: -1, drain_glitch: 1'b0};
        tbl[1] = '{a: 72'h090807060504030201, b: 72'h010203040506070809, c: 72'h5A728A36455412181E,
                   gap: 1'b1, stall_j: 4, stall_len: 3, load_glitch: -1, drain_glitch: 1'b0};
        tbl[2] = '{a: 72'h090807060504030201, b: 72'h010000000100000001, c: 72'h090807060504030201,
                   gap: 1'b0, stall_j: -1, stall_len: 0, load_glitch: -1, drain_glitch: 1'b0};
        tbl[3] = '{a: 72'h141414141414141414, b: 72'h141414141414141414, c: 72'hB0B0B0B0B0B0B0B0B0,
                   gap: 1'b1, stall_j: 2, stall_len: 2, load_glitch: 5, drain_glitch: 1'b1};

        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mult_en   = 1'b1;
        repeat (2) @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_start", start, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", FW'(out_data), '0);
        check("rst_A_flat", A_flat, '0);
        check("rst_B_flat", B_flat, '0);
        reset = 1'b1;
        @(negedge clk);
        check1("in_ready_after_rst", in_ready, 1'b1);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Timeout: no done; err exactly 16 cycles after S_WAIT entry.
        mult_en = 1'b0;
        load_and_start(tbl[0]);
        repeat (16) @(negedge clk);
        check1("err_before_timeout", err, 1'b0);
        @(negedge clk);
        check1("err_at_timeout", err, 1'b1);
        @(negedge clk);
        check1("timeout_in_ready", in_ready, 1'b1);
        check1("timeout_busy", busy, 1'b0);
        check1("timeout_err_sticky", err, 1'b1);
        check1("timeout_out_valid", out_valid, 1'b0);
        mult_en = 1'b1;
        run_vec(tbl[0]);

        // Reset after 10 of 18 elements discards the partial load.
        for (int k = 0; k < 10; k++) send_elem(DW'(k + 1));
        in_valid = 1'b0;
        reset    = 1'b0;
        begin
            int s0;
            @(negedge clk);
            s0 = start_cnt;
            check1("abort_in_ready", in_ready, 1'b0);
            check1("abort_busy", busy, 1'b0);
            check("abort_A_flat", A_flat, '0);
            check("abort_B_flat", B_flat, '0);
            reset = 1'b1;
            @(negedge clk);
            check1("abort_in_ready_rise", in_ready, 1'b1);
            repeat (3) @(negedge clk);
            check("abort_no_start", FW'(start_cnt), FW'(s0));
        end
        run_vec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Byte-stream front end for MatrixMultiplication; sits on both sides of it.
- Accepts A then B elements one at a time over a valid/ready stream and packs them into A_flat/B_flat.
- Pulses start, waits for done, captures C_flat, then streams C out element by element.
- Lets narrow-bus sources (UART, DMA, test host) drive the 72-bit parallel multiplier without a wide interface.

Parameters:
DATA_W, 8, element width in bits
N, 3, matrix dimension (N x N); flat buses are N*N*DATA_W wide
TIMEOUT, 1024, max cycles in S_WAIT before abort

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  DATA_W  incoming matrix element
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept an element
A_flat  output  N*N*DATA_W  packed matrix A to multiplier
B_flat  output  N*N*DATA_W  packed matrix B to multiplier
start  output  1  one-cycle start pulse to multiplier
done  input  1  multiplier result valid
C_flat  input  N*N*DATA_W  packed result from multiplier
out_data  output  DATA_W  outgoing result element
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
busy  output  1  high in any state except S_LOAD with count 0
err  output  1  sticky timeout flag

Behaviour:
- Packing, all flat buses: element (r,c), index k=r*N+c, occupies bits [(N*N-1-k)*DATA_W +: DATA_W]. Element (0,0) is in the MSBs (row-major, MSB-first).
- Reset (reset=0, async): state S_LOAD, count=0, A_flat=B_flat=0, C buffer=0, start=0, in_ready=0 during reset, out_valid=0, out_data=0, busy=0, err=0. in_ready rises the first cycle after reset release.
- Handshake: a transfer occurs on a rising edge where valid&&ready. out_data and out_valid hold stable while out_valid=1 and out_ready=0. in_valid is ignored when in_ready=0.
- S_LOAD:
  - in_ready=1.
  - Elements 0..N*N-1 write A index k=count.
  - Elements N*N..2*N*N-1 write B index k=count-N*N.
  - After the transfer at count=2*N*N-1: count resets to 0, go to S_START.
- S_START:
  - start=1 for exactly this one cycle; in_ready=0; err cleared; go to S_WAIT.
  - Last B accepted at edge t gives start high in cycle t..t+1.
- S_WAIT:
  - start=0; timer counts up from 0.
  - On the first cycle done=1: latch C_flat into the internal buffer, go to S_DRAIN.
  - If the timer reaches TIMEOUT-1 with no done: err=1, go to S_LOAD, count=0; the C buffer keeps its old value.
- S_DRAIN:
  - out_valid=1 and out_data = C buffer element j, for j=0..N*N-1 in row-major order.
  - j advances only on out_valid&&out_ready.
  - After the transfer of j=N*N-1: out_valid=0 next cycle, go to S_LOAD.
- A_flat/B_flat are written only in S_LOAD. They hold stable from start through done and drain.
- done while not in S_WAIT is ignored, including done still high on S_DRAIN entry. A level or pulse done is sampled only once per run.
- Arithmetic: no width conversion. C elements pass through as DATA_W bits; the multiplier owns truncation.
- Mid-operation reset: any state returns immediately to reset values. A partially loaded matrix is discarded.
- Back-to-back runs: new loading starts the cycle after the last drain transfer. No idle cycle is required.

Test Plan:
- Reset, then stream 9,8,7,6,5,4,3,2,1,1,2,3,4,5,6,7,8,9 with in_valid=1 continuously -> A_flat=={9,8,7,6,5,4,3,2,1}, B_flat=={1..9}, start high exactly 1 cycle after 18th accept; with the real multiplier, out stream is 90,114,138,54,69,84,18,24,30 and busy drops after the 9th transfer.
- Same data with in_valid toggled every other cycle, and out_ready low 3 cycles on element 4 -> identical A_flat/B_flat and output order; out_data holds 69 while stalled.
- Multiplier model never asserts done, TIMEOUT=16 -> err=1 exactly 16 cycles after S_WAIT entry, in_ready=1 next cycle; the next run's start clears err.
- Assert reset low after 10 of 18 elements, then reload full data -> no start pulse from the aborted run; the second run completes with correct outputs.
- done pulsed in S_LOAD and S_DRAIN -> no state change and no C buffer update; out values unchanged.
- Two consecutive runs, the second with B = identity -> second output equals A row-major: 9,8,7,6,5,4,3,2,1.
